// File: rtl/reg_file_p2.sv
// Second-generation register file: general, hardwired-input, link and PC registers,
// with a handshaked multi-cycle load and a self-incrementing program counter.
module reg_file_p2 #(
  parameter int DATA_W   = 8,
  parameter int NREGS    = 16,
  parameter int PC_W     = 10,
  parameter int IN_REGS  = 2,
  parameter int LINK_IDX = 14,
  parameter int PC_IDX   = 15
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [2:0]               op_i,
  input  logic [$clog2(NREGS)-1:0] src_i,
  input  logic [$clog2(NREGS)-1:0] dst_i,
  input  logic [3:0]               imm_i,
  input  logic                     pc_inc_i,
  input  logic [DATA_W-1:0]        in_r_i,
  input  logic [DATA_W-1:0]        in_s_i,
  output logic                     ld_req_o,
  input  logic                     ld_valid_i,
  input  logic [DATA_W-1:0]        ld_data_i,
  output logic                     st_valid_o,
  output logic [DATA_W-1:0]        st_data_o,
  output logic [DATA_W-1:0]        rd_a_o,
  output logic [DATA_W-1:0]        rd_b_o,
  output logic [PC_W-1:0]          pc_o,
  output logic                     br_taken_o
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] PC_SEL   = AW'(PC_IDX);
  localparam logic [AW-1:0] LINK_SEL = AW'(LINK_IDX);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MOV   = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_INCR  = 3'd4;
  localparam logic [2:0] OP_DECR  = 3'd5;
  localparam logic [2:0] OP_BIZR  = 3'd6;
  localparam logic [2:0] OP_BNZR  = 3'd7;

  // state       | meaning
  // S_IDLE      | ready for a command, ops complete at the accepting edge
  // S_WAIT_LOAD | load requested, stalled until ld_valid returns the data
  typedef enum logic [0:0] {S_IDLE, S_WAIT_LOAD} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [DATA_W-1:0]  regs_d [NREGS];
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               st_valid_q, st_valid_d;
  logic [DATA_W-1:0]  st_data_q, st_data_d;
  logic               ld_req_q, ld_req_d;
  logic               br_taken_q, br_taken_d;
  logic [AW-1:0]      ld_dst_q, ld_dst_d;

  logic               accept;
  logic               wr_en;
  logic [AW-1:0]      wr_idx;
  logic [DATA_W-1:0]  wr_val;
  logic               br_cond;

  // PC_IDX reads back the live program counter rather than array storage.
  assign rd_a_o = (src_i == PC_SEL) ? pc_q[DATA_W-1:0] : regs_q[src_i];
  assign rd_b_o = (dst_i == PC_SEL) ? pc_q[DATA_W-1:0] : regs_q[dst_i];

  assign cmd_ready_o = (state_q == S_IDLE) && !reset_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

  assign pc_o       = pc_q;
  assign st_valid_o = st_valid_q;
  assign st_data_o  = st_data_q;
  assign ld_req_o   = ld_req_q;
  assign br_taken_o = br_taken_q;

  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    pc_d       = pc_inc_i ? pc_q + PC_W'(1) : pc_q;
    st_valid_d = 1'b0;
    st_data_d  = st_data_q;
    ld_req_d   = 1'b0;
    br_taken_d = 1'b0;
    ld_dst_d   = ld_dst_q;
    wr_en      = 1'b0;
    wr_idx     = dst_i;
    wr_val     = '0;
    br_cond    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_i)
            OP_NOP: ;
            OP_MOV: begin
              wr_en  = 1'b1;
              wr_val = (src_i == dst_i) ? '0 : rd_a_o;
            end
            OP_LOAD: begin
              ld_req_d = 1'b1;
              ld_dst_d = dst_i;
              state_d  = S_WAIT_LOAD;
            end
            OP_STORE: begin
              st_valid_d = 1'b1;
              st_data_d  = rd_a_o;
            end
            OP_INCR: begin
              wr_en  = 1'b1;
              wr_val = rd_b_o + DATA_W'(imm_i);
            end
            OP_DECR: begin
              wr_en  = 1'b1;
              wr_val = rd_b_o - DATA_W'(imm_i);
            end
            OP_BIZR, OP_BNZR: begin
              br_cond = (rd_a_o == '0) ^ (op_i == OP_BNZR);
              if (br_cond) begin
                br_taken_d = 1'b1;
                pc_d       = PC_W'(regs_q[LINK_SEL]);
              end
            end
            default: ;
          endcase
        end
      end
      S_WAIT_LOAD: begin
        if (ld_valid_i) begin
          wr_en   = 1'b1;
          wr_idx  = ld_dst_q;
          wr_val  = ld_data_i;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A PC_IDX write overrides pc_inc; writes to hardwired inputs are dropped.
    if (wr_en) begin
      if (wr_idx == PC_SEL) begin
        pc_d = PC_W'(wr_val);
      end else if (int'(wr_idx) >= IN_REGS) begin
        regs_d[wr_idx] = wr_val;
      end
    end

    for (int i = 0; i < IN_REGS && i < NREGS; i++) begin
      if (i == 0)      regs_d[i] = in_r_i;
      else if (i == 1) regs_d[i] = in_s_i;
      else             regs_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pc_q       <= '0;
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
      ld_req_q   <= 1'b0;
      br_taken_q <= 1'b0;
      ld_dst_q   <= '0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      pc_q       <= pc_d;
      st_valid_q <= st_valid_d;
      st_data_q  <= st_data_d;
      ld_req_q   <= ld_req_d;
      br_taken_q <= br_taken_d;
      ld_dst_q   <= ld_dst_d;
    end
  end

endmodule

// File: tb/tb_reg_file_p2.sv
// Directed bench for reg_file_p2: every expected value below is hand-derived.
module tb_reg_file_p2;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready, pc_inc;
  logic [2:0] op;
  logic [3:0] src, dst, imm;
  logic [7:0] in_r, in_s, ld_data, st_data, rd_a, rd_b;
  logic       ld_req, ld_valid, st_valid, br_taken;
  logic [9:0] pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file_p2 dut (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .op_i(op), .src_i(src), .dst_i(dst), .imm_i(imm), .pc_inc_i(pc_inc),
    .in_r_i(in_r), .in_s_i(in_s), .ld_req_o(ld_req), .ld_valid_i(ld_valid),
    .ld_data_i(ld_data), .st_valid_o(st_valid), .st_data_o(st_data),
    .rd_a_o(rd_a), .rd_b_o(rd_b), .pc_o(pc), .br_taken_o(br_taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] o, input logic [3:0] s, input logic [3:0] d,
                     input logic [3:0] i);
    cmd_valid = 1'b1; op = o; src = s; dst = d; imm = i;
    tick();
    cmd_valid = 1'b0; op = 3'd0;
  endtask

  task automatic peek(input logic [3:0] r, input string tag, input logic [7:0] exp);
    src = r;
    #1;
    check(tag, 32'(rd_a), 32'(exp));
  endtask

  // load with ld_valid arriving in the ld_req cycle
  task automatic quick_load(input logic [3:0] d, input logic [7:0] data);
    cmd(3'd2, 4'd0, d, 4'd0);
    check("ld_req_pulse", 32'(ld_req), 32'd1);
    ld_valid = 1'b1; ld_data = data;
    tick();
    ld_valid = 1'b0;
    check("ld_req_drop", 32'(ld_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; op = '0; src = '0; dst = '0; imm = '0;
    pc_inc = 1'b0; in_r = 8'h3C; in_s = 8'hA5; ld_valid = 1'b0; ld_data = '0;
    tick(); tick();
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_st_valid", 32'(st_valid), 32'd0);
    check("rst_br", 32'(br_taken), 32'd0);
    check("rst_ldreq", 32'(ld_req), 32'd0);
    peek(4'd0, "rst_reg0", 8'h00);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(cmd_ready), 32'd1);
    peek(4'd0, "in_r", 8'h3C);
    peek(4'd1, "in_s", 8'hA5);

    cmd(3'd1, 4'd6, 4'd0, 4'd0);
    peek(4'd0, "mov_to_input", 8'h3C);

    quick_load(4'd6, 8'h55);
    peek(4'd6, "load_r6", 8'h55);
    cmd(3'd1, 4'd6, 4'd7, 4'd0);
    peek(4'd7, "mov_6_7", 8'h55);
    cmd(3'd1, 4'd7, 4'd7, 4'd0);
    peek(4'd7, "mov_clear", 8'h00);
    cmd(3'd1, 4'd6, 4'd7, 4'd0);

    quick_load(4'd8, 8'hFE);
    cmd(3'd4, 4'd0, 4'd8, 4'd3);
    peek(4'd8, "incr_wrap", 8'h01);
    cmd(3'd5, 4'd0, 4'd8, 4'd2);
    peek(4'd8, "decr_wrap", 8'hFF);

    cmd(3'd4, 4'd0, 4'd1, 4'd1);
    peek(4'd1, "input_wr_drop", 8'hA5);

    // stalled load with a second command held on the interface
    cmd(3'd2, 4'd0, 4'd9, 4'd0);
    cmd_valid = 1'b1; op = 3'd4; dst = 4'd9; imm = 4'd1;
    for (int k = 0; k < 3; k++) begin
      check("stall_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    check("stall_ready_last", 32'(cmd_ready), 32'd0);
    check("stall_ldreq", 32'(ld_req), 32'd0);
    ld_valid = 1'b1; ld_data = 8'h9C;
    tick();
    ld_valid = 1'b0;
    check("load_done_ready", 32'(cmd_ready), 32'd1);
    check("load_r9", 32'(rd_b), 32'h9C);
    tick();
    cmd_valid = 1'b0; op = 3'd0;
    check("held_cmd_exec", 32'(rd_b), 32'h9D);

    quick_load(4'd14, 8'h80);
    pc_inc = 1'b1;
    cmd(3'd6, 4'd5, 4'd0, 4'd0);
    pc_inc = 1'b0;
    check("bizr_pc", 32'(pc), 32'h080);
    check("bizr_br", 32'(br_taken), 32'd1);
    tick();
    check("br_one_pulse", 32'(br_taken), 32'd0);
    pc_inc = 1'b1;
    cmd(3'd7, 4'd5, 4'd0, 4'd0);
    pc_inc = 1'b0;
    check("bnzr_not_taken_pc", 32'(pc), 32'h081);
    check("bnzr_not_taken_br", 32'(br_taken), 32'd0);

    cmd(3'd7, 4'd7, 4'd0, 4'd0);
    check("bnzr_taken_pc", 32'(pc), 32'h080);
    cmd(3'd4, 4'd0, 4'd14, 4'd5);
    cmd(3'd6, 4'd5, 4'd0, 4'd0);
    check("link_fresh_pc", 32'(pc), 32'h085);
    cmd(3'd4, 4'd0, 4'd15, 4'd2);
    check("pc_reg_write", 32'(pc), 32'h087);
    peek(4'd15, "pc_readback", 8'h87);

    cmd(3'd3, 4'd7, 4'd0, 4'd0);
    check("st_valid", 32'(st_valid), 32'd1);
    check("st_data", 32'(st_data), 32'h55);
    tick();
    check("st_valid_drop", 32'(st_valid), 32'd0);
    check("st_data_hold", 32'(st_data), 32'h55);

    ld_valid = 1'b1; ld_data = 8'h11;
    tick();
    ld_valid = 1'b0;
    peek(4'd9, "idle_ldvalid_ignored", 8'h9D);

    cmd(3'd2, 4'd0, 4'd10, 4'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h77;
    #1;
    check("rst_abandon_ready", 32'(cmd_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    peek(4'd10, "rst_abandon_r10", 8'h00);
    check("rst_abandon_idle", 32'(cmd_ready), 32'd1);
    check("rst_abandon_pc", 32'(pc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_p2.md
Name: reg_file_p2

Overview:
- Parametrised second-generation CPU register file: general registers, hardwired input registers, a link register and a PC register.
- Executes one register-level op per accepted command: move/clear, load, store, add-immediate, subtract-immediate and conditional branch.
- New in this generation: a handshaked multi-cycle load with a busy stall, and a PC that self-increments.
- Sits between the decoder (command), the data memory (load/store) and the fetch unit (pc).

Parameters:
DATA_W, 8, register width in bits
NREGS, 16, register count (power of two, >= 4)
PC_W, 10, program counter width (PC_W >= DATA_W)
IN_REGS, 2, registers 0..IN_REGS-1 are hardwired inputs
LINK_IDX, 14, register whose value is the branch target
PC_IDX, 15, register index that reads back pc[DATA_W-1:0]

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when cmd_valid&&cmd_ready
op  in  3  0 NOP, 1 MOV, 2 LOAD, 3 STORE, 4 INCR, 5 DECR, 6 BIZR, 7 BNZR
src  in  $clog2(NREGS)  source register index
dst  in  $clog2(NREGS)  destination register index
imm  in  4  immediate for INCR/DECR
pc_inc  in  1  advance pc by 1 (fetch done)
in_r  in  DATA_W  value for register 0
in_s  in  DATA_W  value for register 1 (if IN_REGS >= 2)
ld_req  out  1  load request pulse, address = regs[src]
ld_valid  in  1  load data returned
ld_data  in  DATA_W  load data
st_valid  out  1  store strobe (one cycle)
st_data  out  DATA_W  store data
rd_a  out  DATA_W  combinational read of regs[src]
rd_b  out  DATA_W  combinational read of regs[dst]
pc  out  PC_W  program counter
br_taken  out  1  one-cycle pulse, branch taken

Behaviour:
- Reset: all registers 0, pc 0, st_valid 0, st_data 0, ld_req 0, br_taken 0, FSM to IDLE; cmd_ready 0 during the reset cycle. A reset in WAIT_LOAD abandons the load, and a later ld_valid is ignored.
- Input registers: every cycle regs[i] <= input i for i < IN_REGS. Writes aimed at them are dropped silently.
- Reads: reading PC_IDX returns pc[DATA_W-1:0]. A read during a write returns the old value, with no bypass.
- FSM IDLE: cmd_ready = 1; accepted ops execute and take effect at that edge.
  - MOV: if src == dst, clear regs[dst]; else regs[dst] <= regs[src].
  - INCR: regs[dst] <= regs[dst] + imm, mod 2^DATA_W. Wraps with no flag.
  - DECR: regs[dst] <= regs[dst] - imm, mod 2^DATA_W.
  - STORE: st_data <= regs[src] and st_valid = 1 for one cycle. st_data holds its value afterwards.
  - BIZR: if regs[src] == 0, pc <= zero-extended regs[LINK_IDX] and br_taken pulses; else no change.
  - BNZR: the same, but taken when regs[src] != 0.
  - LOAD: ld_req = 1 for one cycle, then go to WAIT_LOAD and latch dst.
- FSM WAIT_LOAD: cmd_ready = 0.
  - On ld_valid: regs[latched dst] <= ld_data, return to IDLE. A new command may be accepted the cycle after.
  - ld_valid in the ld_req cycle itself is legal and completes the load.
  - ld_valid while in IDLE is ignored.
- Writes to PC_IDX (MOV, LOAD, INCR, DECR): pc[DATA_W-1:0] <= value and pc upper bits <= 0.
- pc_inc: pc <= pc + 1, wrapping at 2^PC_W.
- Precedence in one cycle: reset > branch taken / PC_IDX write > pc_inc. pc_inc is lost when a branch is taken.
- Writes to LINK_IDX take effect at the edge; a branch issued in the next cycle uses the new value.
- Maximum throughput is one op per cycle, except LOAD (>= 1 extra cycle).

Test Plan:
- Reset, then in_r=0x3C, in_s=0xA5 -> rd_a with src=0 is 0x3C; MOV dst=0 from src=6 leaves reg0 = 0x3C.
- MOV 6->7 with reg6=0x55 -> reg7=0x55; MOV 7->7 -> reg7=0x00.
- reg8=0xFE, INCR dst=8 imm=3 -> 0x01; DECR dst=8 imm=2 -> 0xFF.
- LOAD dst=9, ld_valid held off 3 cycles -> cmd_ready low for 3 cycles, then reg9=ld_data=0x9C. A second command held during the stall is accepted one cycle after ld_valid.
- reg14=0x80, reg5=0, BIZR src=5 with pc_inc=1 -> pc=0x080 (not 0x081), br_taken pulses once. BNZR src=5 -> pc advances only by pc_inc.
- STORE src=7 (0x55) -> st_valid pulses once with st_data=0x55. Reset asserted in WAIT_LOAD, then ld_valid -> no register written, FSM IDLE.
